// File: rtl/tft_init_pkg.sv
// Shared types and constants for the TFT panel init sequencer:
// FSM states, init ROM entry codes and contents, window commands.
package tft_init_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RST_LO,
        RST_WAIT,
        FETCH,
        SEND,
        DLY,
        WIN,
        FILL,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_SHIFT,
        SPI_GAP
    } spi_state_t;

    localparam logic [1:0] ROM_CMD  = 2'b00;
    localparam logic [1:0] ROM_DATA = 2'b01;
    localparam logic [1:0] ROM_DLY  = 2'b10;
    localparam logic [1:0] ROM_END  = 2'b11;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int ROM_AW = 4;

    // Entry = {type[1:0], value[7:0]}; any unused address reads as end.
    function automatic logic [9:0] init_rom(input logic [ROM_AW-1:0] addr);
        logic [9:0] e;
        case (addr)
            4'd0:    e = {ROM_CMD, 8'h11};
            4'd1:    e = {ROM_DLY, 8'd2};
            4'd2:    e = {ROM_CMD, 8'h29};
            default: e = {ROM_END, 8'h00};
        endcase
        return e;
    endfunction

    // Window setup stream, returns {rs, byte} for step 0..10.
    function automatic logic [8:0] win_entry(input logic [3:0] idx,
                                             input logic [7:0] h_last,
                                             input logic [7:0] v_last);
        logic [8:0] e;
        case (idx)
            4'd0:    e = {1'b0, CMD_CASET};
            4'd4:    e = {1'b1, h_last};
            4'd5:    e = {1'b0, CMD_RASET};
            4'd9:    e = {1'b1, v_last};
            4'd10:   e = {1'b0, CMD_RAMWR};
            default: e = {1'b1, 8'h00};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/tft_spi_byte.sv
// Serial byte shifter for the panel bus: one byte per accepted request.
// Ports: sys_clk, sys_rst (async, high); tx_valid/tx_rs/tx_byte in, tx_ready out;
// scl, sda, cs, rs drive the panel. Frame = 16*CLK_DIV shift + 2*CLK_DIV CS gap.
module tft_spi_byte
    import tft_init_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       tx_valid,
    input  logic       tx_rs,
    input  logic [7:0] tx_byte,
    output logic       tx_ready,
    output logic       scl,
    output logic       sda,
    output logic       cs,
    output logic       rs
);

    localparam int DW = $clog2(2 * CLK_DIV + 1);
    localparam logic [DW-1:0] HALF_END = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] GAP_END  = DW'(2 * CLK_DIV - 1);

    spi_state_t    st;
    logic [DW-1:0] div;
    logic [2:0]    bit_cnt;
    logic [7:0]    sh;
    logic          accept;

    // Ready in the last gap cycle lets back-to-back bytes land exactly
    // one frame apart.
    assign tx_ready = (st == SPI_IDLE) || (st == SPI_GAP && div == GAP_END);
    assign accept   = tx_valid && tx_ready;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            st      <= SPI_IDLE;
            div     <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            scl     <= 1'b0;
            sda     <= 1'b0;
            cs      <= 1'b1;
            rs      <= 1'b0;
        end else if (accept) begin
            st      <= SPI_SHIFT;
            div     <= '0;
            bit_cnt <= '0;
            sh      <= tx_byte;
            sda     <= tx_byte[7];
            rs      <= tx_rs;
            cs      <= 1'b0;
            scl     <= 1'b0;
        end else begin
            case (st)
                SPI_SHIFT: begin
                    if (div == HALF_END) begin
                        div <= '0;
                        if (!scl) begin
                            scl <= 1'b1;
                        end else begin
                            // SDA only moves on the falling edge of SCL.
                            scl <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                cs  <= 1'b1;
                                sda <= 1'b0;
                                st  <= SPI_GAP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                sh      <= {sh[6:0], 1'b0};
                                sda     <= sh[6];
                            end
                        end
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                SPI_GAP: begin
                    if (div == GAP_END) begin
                        div <= '0;
                        st  <= SPI_IDLE;
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                default: div <= '0;
            endcase
        end
    end

endmodule

// File: rtl/tft_init_seq.sv
// TFT panel init sequencer: reset pulse, ROM-driven command list, optional fill.
// Ports: sys_clk, sys_rst (async, high), start, fill_color; busy, done, LCD_* bus.
// Define TFT_INIT_FILL_EN to add the window setup and full-screen colour fill.
module tft_init_seq
    import tft_init_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int RST_LOW_CYC  = 200000,
    parameter int RST_WAIT_CYC = 2400000,
    parameter int DLY_UNIT     = 50000,
    parameter int H_RES        = 128,
    parameter int V_RES        = 160
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [15:0] fill_color,
    output logic        busy,
    output logic        done,
    output logic        LCD_SCL,
    output logic        LCD_SDA,
    output logic        LCD_RS,
    output logic        LCD_CS,
    output logic        LCD_RST
);

    localparam logic [31:0] LO_END = 32'(RST_LOW_CYC - 1);
    // The fetch/handshake pipeline eats 2 cycles, so the first CS fall
    // lands exactly RST_WAIT_CYC cycles after LCD_RST rises.
    localparam logic [31:0] WAIT_END =
        (RST_WAIT_CYC > 3) ? 32'(RST_WAIT_CYC - 3) : 32'd0;

    state_t            state;
    logic [ROM_AW-1:0] addr;
    logic [31:0]       cnt;
    logic [31:0]       dly_end;
    logic [31:0]       dly_len;
    logic [9:0]        entry;
    logic              tx_valid;
    logic              tx_rs;
    logic [7:0]        tx_byte;
    logic              tx_ready;

    assign entry   = init_rom(addr);
    assign dly_len = 32'(entry[7:0]) * 32'(DLY_UNIT);

`ifdef TFT_INIT_FILL_EN
    localparam int PW = $clog2(H_RES * V_RES + 1);
    localparam logic [PW-1:0] TOTAL = PW'(H_RES * V_RES);

    logic [15:0]   color;
    logic [PW-1:0] pix;
    logic          hi;
    logic [3:0]    win_idx;
    logic [8:0]    win_ent;

    assign win_ent = win_entry(win_idx, 8'(H_RES - 1), 8'(V_RES - 1));
`else
    logic unused_fill;
    assign unused_fill = ^{fill_color, 32'(H_RES), 32'(V_RES)};
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            addr     <= '0;
            cnt      <= '0;
            dly_end  <= '0;
            tx_valid <= 1'b0;
            tx_rs    <= 1'b0;
            tx_byte  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            LCD_RST  <= 1'b1;
`ifdef TFT_INIT_FILL_EN
            color    <= '0;
            pix      <= '0;
            hi       <= 1'b0;
            win_idx  <= '0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        LCD_RST <= 1'b0;
                        cnt     <= '0;
                        addr    <= '0;
`ifdef TFT_INIT_FILL_EN
                        color   <= fill_color;
`endif
                        state   <= RST_LO;
                    end
                end
                RST_LO: begin
                    if (cnt == LO_END) begin
                        cnt     <= '0;
                        LCD_RST <= 1'b1;
                        state   <= RST_WAIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RST_WAIT: begin
                    if (cnt == WAIT_END) begin
                        cnt   <= '0;
                        state <= FETCH;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                FETCH: begin
                    case (entry[9:8])
                        ROM_CMD, ROM_DATA: begin
                            tx_byte  <= entry[7:0];
                            tx_rs    <= entry[8];
                            tx_valid <= 1'b1;
                            addr     <= addr + ROM_AW'(1);
                            state    <= SEND;
                        end
                        ROM_DLY: begin
                            // Same 2-cycle pipeline offset as the reset wait.
                            cnt     <= '0;
                            dly_end <= (dly_len > 32'd2) ? dly_len - 32'd2 : 32'd0;
                            addr    <= addr + ROM_AW'(1);
                            state   <= DLY;
                        end
                        default: begin
`ifdef TFT_INIT_FILL_EN
                            win_idx <= '0;
                            state   <= WIN;
`else
                            if (tx_ready) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end
`endif
                        end
                    endcase
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= FETCH;
                    end
                end
                DLY: begin
                    // Delay runs only once the previous byte has left the bus.
                    if (tx_ready) begin
                        if (cnt == dly_end) begin
                            cnt   <= '0;
                            state <= FETCH;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                end
`ifdef TFT_INIT_FILL_EN
                WIN: begin
                    if (!tx_valid) begin
                        tx_byte  <= win_ent[7:0];
                        tx_rs    <= win_ent[8];
                        tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (win_idx == 4'd10) begin
                            pix   <= '0;
                            hi    <= 1'b1;
                            state <= FILL;
                        end else begin
                            win_idx <= win_idx + 4'd1;
                        end
                    end
                end
                FILL: begin
                    if (!tx_valid) begin
                        if (pix == TOTAL) begin
                            if (tx_ready) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end else begin
                            tx_byte  <= hi ? color[15:8] : color[7:0];
                            tx_rs    <= 1'b1;
                            tx_valid <= 1'b1;
                        end
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        hi       <= !hi;
                        if (!hi) begin
                            pix <= pix + PW'(1);
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    tft_spi_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_spi (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .tx_valid (tx_valid),
        .tx_rs    (tx_rs),
        .tx_byte  (tx_byte),
        .tx_ready (tx_ready),
        .scl      (LCD_SCL),
        .sda      (LCD_SDA),
        .cs       (LCD_CS),
        .rs       (LCD_RS)
    );

endmodule

// File: doc/tft_init_seq.md
TFT_INIT_SEQ -- requirements
Module: tft_init_seq

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: sys_clk cycles per SCL half-period, legal range >=1.
REQ-002 SHALL have parameter RST_LOW_CYC, default 200000: number of cycles LCD_RST is held low.
REQ-003 SHALL have parameter RST_WAIT_CYC, default 2400000: wait in cycles after LCD_RST is released.
REQ-004 SHALL have parameter DLY_UNIT, default 50000: cycles per delay tick for ROM delay entries.
REQ-005 SHALL have parameters H_RES, default 128, and V_RES, default 160: fill window size in pixels.
REQ-006 SHALL have port sys_clk, input, 1 bit: the single clock for the block.
REQ-007 SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: one-cycle pulse that launches the sequence.
REQ-009 SHALL have port fill_color, input, 16 bits: RGB565 colour, sampled when start is accepted.
REQ-010 SHALL have port busy, output, 1 bit: high while the sequence is running.
REQ-011 SHALL have port done, output, 1 bit: high and held after the sequence completes.
REQ-012 SHALL have ports LCD_SCL, LCD_SDA, LCD_RS, LCD_CS, LCD_RST, all outputs, 1 bit: the serial panel bus.

Function
REQ-013 SHALL implement states IDLE, RST_LO, RST_WAIT, FETCH, SEND, DLY, WIN, FILL and DONE.
REQ-014 SHALL, in IDLE or DONE, accept start by clearing done, setting busy next cycle and entering RST_LO.
REQ-015 SHALL ignore start while busy.
REQ-016 SHALL drive LCD_RST=0 for exactly RST_LOW_CYC cycles in RST_LO, then LCD_RST=1 for RST_WAIT_CYC cycles in RST_WAIT.
REQ-017 SHALL, in FETCH, read the init ROM at an address starting at 0, using 10-bit entries [9:8] type and [7:0] value.
REQ-018 SHALL decode the ROM type as: 00 = command (RS=0), 01 = data (RS=1), 10 = delay of value*DLY_UNIT cycles, 11 = end of list.
REQ-019 SHALL, for each byte: lower CS, then send 8 bits MSB first with SDA changing only while SCL=0; each SCL level lasts CLK_DIV cycles; RS is valid from CS fall to CS rise.
REQ-020 SHALL raise CS 0 cycles after the 8th SCL fall and hold it high for 2*CLK_DIV cycles before the next byte.
REQ-021 SHALL take 18*CLK_DIV cycles per byte, including the CS gap.
REQ-022 SHALL, on ROM end, go to WIN and send 0x2A,0,0,0,H_RES-1, then 0x2B,0,0,0,V_RES-1, then 0x2C.
REQ-023 SHALL, in FILL, send H_RES*V_RES pixels, high byte first, as data; the pixel counter wraps in width ceil(log2(H_RES*V_RES+1)).
REQ-024 SHALL, after the last pixel byte, enter DONE with busy=0 and done=1 on the same edge.

Reset
REQ-025 SHALL, while sys_rst=1 at any time including mid-byte, immediately force LCD_SCL=0, LCD_SDA=0, LCD_RS=0, LCD_CS=1, LCD_RST=1, busy=0, done=0, state=IDLE, and all counters to 0.
REQ-026 SHALL not emit a partial byte after reset is released.

Configuration
REQ-027 SHALL, with TFT_INIT_FILL_EN defined, run WIN and FILL as described.
REQ-028 SHALL, without TFT_INIT_FILL_EN, go from ROM end directly to DONE; fill_color is then unused.

Structure
REQ-029 SHALL place in package tft_init_pkg: the state enum, the ROM type codes, the init ROM contents function, and the window command constants 0x2A/0x2B/0x2C.
REQ-030 SHALL implement the byte shifter as sub-module tft_spi_byte (inputs tx_valid, tx_rs, tx_byte; output tx_ready; drives SCL/SDA/CS/RS).

Verification
REQ-031 SHALL verify: assert reset mid-byte at CLK_DIV=2 -> CS=1, SCL=0 and LCD_RST=1 within the same cycle, and no SCL edges until the next start.
REQ-032 SHALL verify: start with RST_LOW_CYC=10, RST_WAIT_CYC=20 -> LCD_RST low exactly 10 cycles, with the first CS fall 20 cycles later.
REQ-033 SHALL verify: ROM {cmd 0x11, delay 2, cmd 0x29, end} with DLY_UNIT=5 -> bytes 0x11 (RS=0), then 10 idle cycles, then 0x29 (RS=0).
REQ-034 SHALL verify: fill enabled, H_RES=2, V_RES=2, fill_color=0xF800 -> window bytes per REQ-022, then 8 data bytes F8,00 repeated, then done=1.
REQ-035 SHALL verify: start pulsed while busy -> no restart and the byte count unchanged; start after done -> done falls and the full sequence repeats.
REQ-036 SHALL verify: macro undefined -> done rises after the ROM end with no 0x2A sent.
